if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameters SHALL be: XLEN, 32, PC/address width; RESET_PC, 0, PC value loaded on reset; PC_STEP, 4, sequential PC increment; DEPTH, 4, fetch-buffer entries (power of 2, >=2).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 CLK  input  1  clock, all state updates on rising edge.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 Branch_Sig  input  1  redirect request, highest priority after RST.
REQ-006 PC_branch  input  XLEN  redirect target, sampled when Branch_Sig=1.
REQ-007 IMEM_REQ  output  1  instruction-memory read strobe.
REQ-008 IMEM_ADDR  output  XLEN  read address; equals current fetch PC.
REQ-009 IMEM_DATA  input  32  read data, valid exactly one cycle after an accepted IMEM_REQ.
REQ-010 ID_VALID  output  1  head buffer entry available to decode.
REQ-011 ID_READY  input  1  decode accepts head entry.
REQ-012 ID_INSTR  output  32  head entry instruction.
REQ-013 ID_PC  output  XLEN  head entry PC.
REQ-014 COUNT  output  clog2(DEPTH)+1  occupied buffer entries.

Function
REQ-015 Fetch PC register SHALL issue IMEM_REQ=1 iff RST=0, Branch_Sig=0 and (COUNT + inflight) < DEPTH, using registered COUNT/inflight only (same-cycle pop frees space next cycle).
REQ-016 On each issued request, fetch PC SHALL advance by PC_STEP, wrapping modulo 2^XLEN (0xFFFFFFFC + 4 -> 0x00000000).
REQ-017 An inflight flag and inflight PC SHALL be registered on each request; in the following cycle IMEM_DATA and inflight PC SHALL be pushed as one entry at the buffer tail.
REQ-018 Buffer SHALL be a circular FIFO of DEPTH entries with wrapping read/write pointers; push and pop in the same cycle SHALL leave COUNT unchanged.
REQ-019 ID_VALID SHALL equal (COUNT != 0); ID_INSTR/ID_PC SHALL present the head entry combinationally from buffer state.
REQ-020 A pop SHALL occur iff ID_VALID=1 and ID_READY=1 at the clock edge; ID_READY while empty SHALL have no effect.
REQ-021 Buffer SHALL never overflow; credit rule in REQ-015 guarantees a slot for every returning word.
REQ-022 Branch_Sig=1 SHALL at the edge: load fetch PC with PC_branch, clear buffer (COUNT=0, pointers=0), clear inflight so the word returning next cycle is dropped.
REQ-023 Branch_Sig=1 SHALL override a simultaneous pop or push; no entry is delivered to decode as accepted that cycle.
REQ-024 First request after a redirect SHALL issue the cycle after Branch_Sig with IMEM_ADDR=PC_branch.
REQ-025 Branch_Sig held high for multiple cycles SHALL keep IMEM_REQ=0 and reload fetch PC each cycle with the last PC_branch.
REQ-026 Steady state with ID_READY=1 and no branch SHALL sustain one instruction per cycle after 2-cycle fill latency (request -> data -> ID_VALID).

Reset
REQ-027 While RST=1 at an edge: fetch PC=RESET_PC, COUNT=0, pointers=0, inflight=0.
REQ-028 Outputs during/after reset: IMEM_REQ=0 while RST=1, ID_VALID=0, COUNT=0; ID_INSTR/ID_PC undefined when ID_VALID=0.
REQ-029 Reset mid-operation SHALL discard buffer contents and any inflight word; first post-reset request SHALL use IMEM_ADDR=RESET_PC.
REQ-030 RST SHALL take priority over Branch_Sig.

Verification
REQ-031 Release RST, ID_READY=1, memory returns addr-derived data -> IMEM_ADDR 0,4,8,... each cycle; ID_VALID first high 2 cycles after first request; ID_PC 0,4,8 in order.
REQ-032 ID_READY=0 from release -> exactly 4 requests (0..0xC), COUNT reaches 4, IMEM_REQ stays 0; ID_READY=1 one cycle -> one pop, one new request next cycle at 0x10.
REQ-033 Branch_Sig=1, PC_branch=0x100 while COUNT=3 and request inflight -> next cycle COUNT=0, ID_VALID=0, returning word dropped, IMEM_ADDR=0x100; ID_PC=0x100 two cycles later.
REQ-034 Branch_Sig and ID_VALID&ID_READY same cycle -> no extra pop observed, buffer empty afterwards.
REQ-035 RESET_PC=0xFFFFFFF8, ID_READY=1 -> IMEM_ADDR sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-036 RST asserted with COUNT=2 and request inflight -> next cycle COUNT=0, ID_VALID=0, no push of inflight word; after release IMEM_ADDR=RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: a sequential PC feeds a one-cycle-latency instruction
// memory, and returned words queue in a circular buffer that decode drains.
module if_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int unsigned     PC_STEP  = 4,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Branch_Sig,
  input  logic [XLEN-1:0]          PC_branch,
  output logic                     IMEM_REQ,
  output logic [XLEN-1:0]          IMEM_ADDR,
  input  logic [31:0]              IMEM_DATA,
  output logic                     ID_VALID,
  input  logic                     ID_READY,
  output logic [31:0]              ID_INSTR,
  output logic [XLEN-1:0]          ID_PC,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [XLEN-1:0]  STEP_C  = XLEN'(PC_STEP);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             infl_q, infl_d;
  logic [XLEN-1:0]  infl_pc_q, infl_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      instr_mem_q [DEPTH];
  logic [XLEN-1:0]  pc_mem_q    [DEPTH];

  logic [CNT_W:0]   occupancy_s;
  logic             req_s;
  logic             push_s;
  logic             pop_s;

  // Credit check counts the inflight word so every returning word has a slot.
  assign occupancy_s = {1'b0, count_q} + {{CNT_W{1'b0}}, infl_q};
  assign req_s       = !RST && !Branch_Sig && (occupancy_s < DEPTH_C);
  assign push_s      = infl_q && !RST && !Branch_Sig;
  assign pop_s       = (count_q != {CNT_W{1'b0}}) && ID_READY && !RST && !Branch_Sig;

  assign IMEM_REQ  = req_s;
  assign IMEM_ADDR = pc_q;
  assign ID_VALID  = (count_q != {CNT_W{1'b0}});
  assign ID_INSTR  = instr_mem_q[rd_ptr_q];
  assign ID_PC     = pc_mem_q[rd_ptr_q];
  assign COUNT     = count_q;

  always_comb begin
    pc_d      = pc_q;
    infl_d    = infl_q;
    infl_pc_d = infl_pc_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (RST) begin
      pc_d     = RESET_PC;
      infl_d   = 1'b0;
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else if (Branch_Sig) begin
      // Redirect flushes everything, including the word still in flight.
      pc_d     = PC_branch;
      infl_d   = 1'b0;
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      infl_d   = req_s;
      wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
      count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
      if (req_s) begin
        pc_d      = pc_q + STEP_C;
        infl_pc_d = pc_q;
      end else begin
        pc_d      = pc_q;
        infl_pc_d = infl_pc_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    pc_q      <= pc_d;
    infl_q    <= infl_d;
    infl_pc_q <= infl_pc_d;
    wr_ptr_q  <= wr_ptr_d;
    rd_ptr_q  <= rd_ptr_d;
    count_q   <= count_d;
  end

  // Buffer storage carries no reset; COUNT alone qualifies its contents.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      instr_mem_q[wr_ptr_q] <= IMEM_DATA;
      pc_mem_q[wr_ptr_q]    <= infl_pc_q;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random traffic, compared
// against a queue-based model of the fetch stream.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        br;
  logic [31:0] pcb;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [2:0]  count;

  logic        rst2;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        id_valid2;
  logic [31:0] id_instr2;
  logic [31:0] id_pc2;
  logic [2:0]  count2;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_q [$];
  logic [31:0] m_pc;
  logic        m_infl;
  logic [31:0] m_infl_pc;
  bit          model_ok = 1'b0;

  if_fetch_unit dut (
    .CLK(clk), .RST(rst), .Branch_Sig(br), .PC_branch(pcb),
    .IMEM_REQ(imem_req), .IMEM_ADDR(imem_addr), .IMEM_DATA(imem_data),
    .ID_VALID(id_valid), .ID_READY(id_ready), .ID_INSTR(id_instr),
    .ID_PC(id_pc), .COUNT(count)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .CLK(clk), .RST(rst2), .Branch_Sig(1'b0), .PC_branch(32'h0000_0000),
    .IMEM_REQ(imem_req2), .IMEM_ADDR(imem_addr2), .IMEM_DATA(32'h0000_0000),
    .ID_VALID(id_valid2), .ID_READY(1'b1), .ID_INSTR(id_instr2),
    .ID_PC(id_pc2), .COUNT(count2)
  );

  function automatic logic [31:0] fmem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers one cycle after a request; garbage otherwise.
  always @(posedge clk) imem_data <= imem_req ? fmem(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s_rst, input logic s_br, input logic [31:0] s_pcb,
                      input logic s_rdy);
    logic m_req;
    rst = s_rst; br = s_br; pcb = s_pcb; id_ready = s_rdy;
    #1;
    m_req = !s_rst && !s_br && ((m_q.size() + int'(m_infl)) < 4);
    if (model_ok) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
      chk("imem_addr", imem_addr, m_pc);
      chk("count", {29'b0, count}, 32'(m_q.size()));
      chk("id_valid", {31'b0, id_valid}, {31'b0, (m_q.size() != 0)});
      if (m_q.size() != 0) begin
        chk("id_pc", id_pc, m_q[0]);
        chk("id_instr", id_instr, fmem(m_q[0]));
      end
    end
    if (s_rst) begin
      m_q.delete(); m_pc = 32'h0000_0000; m_infl = 1'b0;
    end else if (s_br) begin
      m_q.delete(); m_pc = s_pcb; m_infl = 1'b0;
    end else begin
      if (m_q.size() != 0 && s_rdy) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_pc);
      if (m_q.size() > 4) begin
        checks++; errors++;
        $error("FAIL model_overflow observed=%0d expected<=4", m_q.size());
      end
      m_infl = m_req;
      if (m_req) begin
        m_infl_pc = m_pc;
        m_pc = m_pc + 32'd4;
      end
    end
    model_ok = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] wrap_exp [3];
    int unsigned r;
    logic        r_rst, r_br, r_rdy;
    logic [31:0] r_pcb;
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    rst2 = 1'b1;
    m_pc = 32'h0; m_infl = 1'b0; m_infl_pc = 32'h0;

    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    // Streaming with decode always ready.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Decode stalled: buffer fills, one pop frees one request.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    // Redirect with COUNT=3 and a word in flight.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Redirect coinciding with a pop.
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Redirect held for several cycles.
    step(1'b0, 1'b1, 32'h0000_0300, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0340, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0380, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Reset mid-operation with COUNT=2 and a word in flight.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Address wrap on the second instance.
    rst2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("wrap_addr", imem_addr2, wrap_exp[k]);
      chk("wrap_req", {31'b0, imem_req2}, 32'd1);
      step(1'b0, 1'b0, 32'h0, 1'b1);
    end
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r     = $urandom_range(0, 99);
      r_rst = (r < 2);
      r_br  = (r >= 2) && (r < 12);
      r_pcb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
      r_rdy = ($urandom_range(0, 2) != 0);
      step(r_rst, r_br, r_pcb, r_rdy);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
